// File: rtl/mem_arb.sv
// Single-port memory arbiter: serializes fetch (if_*) and load/store (ls_*) onto one memory.
// Define ARB_RR_EN for round-robin arbitration; otherwise ls has fixed priority over if.
`timescale 1ns/1ps
module mem_arb #(
    parameter int AW      = 16,
    parameter int DW      = 32,
    parameter int MEM_LAT = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_gnt,
    output logic          if_valid,
    output logic [DW-1:0] if_rdata,
    input  logic          ls_req,
    input  logic          ls_we,
    input  logic [AW-1:0] ls_addr,
    input  logic [DW-1:0] ls_wdata,
    output logic          ls_gnt,
    output logic          ls_valid,
    output logic [DW-1:0] ls_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    if (MEM_LAT < 1 || MEM_LAT > 15) begin : g_bad_lat
        $error("mem_arb: MEM_LAT must be within 1..15");
    end

    localparam logic [3:0] LAT4 = 4'(MEM_LAT);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t        state, state_nxt;
    logic [3:0]    cnt;
    logic          owner_ls;
    logic          we_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic          pick_ls;
    logic          start;
    logic          lat_hit;

    assign start   = (state == IDLE) && (if_req || ls_req);
    assign lat_hit = (cnt == LAT4);

`ifdef ARB_RR_EN
    // 1 = ls was granted last; reset value makes ls win the first tie
    logic last_ls;

    always_ff @(posedge clk) begin
        if (rst)        last_ls <= 1'b0;
        else if (start) last_ls <= pick_ls;
    end

    assign pick_ls = ls_req && (!if_req || !last_ls);
`else
    assign pick_ls = ls_req;
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (if_req || ls_req) state_nxt = BUSY;
            BUSY:    if (lat_hit) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Winner's request is frozen at the grant edge; requesters may change inputs afterwards
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= 4'd0;
            owner_ls <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            if_rdata <= '0;
            ls_rdata <= '0;
        end else begin
            if (start) begin
                cnt      <= 4'd0;
                owner_ls <= pick_ls;
                we_q     <= pick_ls & ls_we;
                addr_q   <= pick_ls ? ls_addr : if_addr;
                wdata_q  <= pick_ls ? ls_wdata : '0;
            end else if (state == BUSY && !lat_hit) begin
                cnt <= cnt + 4'd1;
            end
            if (state == BUSY && lat_hit && !we_q) begin
                if (owner_ls) ls_rdata <= mem_rdata;
                else          if_rdata <= mem_rdata;
            end
        end
    end

    always_comb begin
        if_gnt    = 1'b0;
        ls_gnt    = 1'b0;
        if_valid  = 1'b0;
        ls_valid  = 1'b0;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        case (state)
            BUSY: if (cnt == 4'd0) begin
                mem_en = 1'b1;
                mem_we = we_q;
                if_gnt = !owner_ls;
                ls_gnt = owner_ls;
            end
            DONE: begin
                if_valid = !owner_ls;
                ls_valid = owner_ls;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_arb.sv
// Bench for mem_arb: three instances (MEM_LAT 1, 3, 15) with memory models, directed
// scenarios plus random traffic checked against a transaction-schedule reference model.
`timescale 1ns/1ps
module tb_mem_arb;

    localparam int NI = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        if_req   [NI];
    logic [15:0] if_addr  [NI];
    logic        if_gnt   [NI];
    logic        if_valid [NI];
    logic [31:0] if_rdata [NI];
    logic        ls_req   [NI];
    logic        ls_we    [NI];
    logic [15:0] ls_addr  [NI];
    logic [31:0] ls_wdata [NI];
    logic        ls_gnt   [NI];
    logic        ls_valid [NI];
    logic [31:0] ls_rdata [NI];
    logic        mem_en   [NI];
    logic        mem_we   [NI];
    logic [15:0] mem_addr [NI];
    logic [31:0] mem_wdata[NI];
    logic [31:0] mem_rdata[NI];

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    function automatic logic [31:0] init_word(input logic [7:0] a);
        return (a == 8'h04) ? 32'h1234ABCD : {24'hC0FFEE, a};
    endfunction

    function automatic int lat_of(input int k);
        return (k == 0) ? 1 : ((k == 1) ? 3 : 15);
    endfunction

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int L = (g == 0) ? 1 : ((g == 1) ? 3 : 15);
        logic [31:0] mem  [256];
        logic [31:0] pipe [16];
        logic        init_done = 1'b0;

        mem_arb #(.AW(16), .DW(32), .MEM_LAT(L)) u_dut (
            .clk(clk), .rst(rst),
            .if_req(if_req[g]), .if_addr(if_addr[g]), .if_gnt(if_gnt[g]),
            .if_valid(if_valid[g]), .if_rdata(if_rdata[g]),
            .ls_req(ls_req[g]), .ls_we(ls_we[g]), .ls_addr(ls_addr[g]),
            .ls_wdata(ls_wdata[g]), .ls_gnt(ls_gnt[g]), .ls_valid(ls_valid[g]),
            .ls_rdata(ls_rdata[g]),
            .mem_en(mem_en[g]), .mem_we(mem_we[g]), .mem_addr(mem_addr[g]),
            .mem_wdata(mem_wdata[g]), .mem_rdata(mem_rdata[g])
        );

        // Memory with read data appearing L cycles after the mem_en cycle
        always @(posedge clk) begin
            if (!init_done) begin
                for (int a = 0; a < 256; a++) mem[a] <= init_word(8'(a));
                init_done <= 1'b1;
            end else if (mem_en[g] && mem_we[g]) begin
                mem[mem_addr[g][7:0]] <= mem_wdata[g];
            end
            pipe[0] <= (mem_en[g] && !mem_we[g]) ? mem[mem_addr[g][7:0]] : 32'h0BAD_F00D;
            for (int i = 1; i < 16; i++) pipe[i] <= pipe[i-1];
        end
        assign mem_rdata[g] = pipe[L-1];
    end

    // Reference model: one transaction at a time, described by its grant cycle m_g
    int          m_g;
    bit          m_ls, m_we, m_last_ls;
    logic [15:0] m_addr;
    logic [31:0] m_wdata, m_rd;
    logic [31:0] e_if_rdata, e_ls_rdata;
    logic [31:0] smem [NI][256];
    bit          e_if_gnt, e_ls_gnt, e_if_valid, e_ls_valid, e_mem_en, e_mem_we, e_busy;

    task automatic tick();
        @(negedge clk);
        cyc++;
    endtask

    task automatic clear_inputs();
        for (int k = 0; k < NI; k++) begin
            if_req[k] = 1'b0;  if_addr[k] = '0;
            ls_req[k] = 1'b0;  ls_we[k] = 1'b0;
            ls_addr[k] = '0;   ls_wdata[k] = '0;
        end
    endtask

    task automatic model_reset();
        m_g = cyc - 100;
        m_ls = 1'b0;  m_we = 1'b0;  m_last_ls = 1'b0;
        m_addr = '0;  m_wdata = '0;  m_rd = '0;
        e_if_rdata = '0;
        e_ls_rdata = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        tick();
        tick();
        rst = 1'b0;
        model_reset();
    endtask

    // BUSY for L+1 cycles after the grant cycle, then one DONE cycle
    task automatic model_expect(input int k);
        int L;
        L = lat_of(k);
        e_busy     = (cyc >= m_g) && (cyc <= m_g + L);
        e_mem_en   = (cyc == m_g);
        e_mem_we   = e_mem_en && m_we;
        e_if_gnt   = e_mem_en && !m_ls;
        e_ls_gnt   = e_mem_en && m_ls;
        e_if_valid = (cyc == m_g + L + 1) && !m_ls;
        e_ls_valid = (cyc == m_g + L + 1) && m_ls;
        if (e_if_valid)          e_if_rdata = m_rd;
        if (e_ls_valid && !m_we) e_ls_rdata = m_rd;
    endtask

    task automatic model_sample(input int k);
        int L;
        bit take_ls;
        L = lat_of(k);
        if (cyc < m_g + L + 2) return;
        if (!if_req[k] && !ls_req[k]) return;
        if (if_req[k] && ls_req[k]) begin
`ifdef ARB_RR_EN
            take_ls = !m_last_ls;
`else
            take_ls = 1'b1;
`endif
        end else begin
            take_ls = ls_req[k];
        end
        m_last_ls = take_ls;
        m_g       = cyc + 1;
        m_ls      = take_ls;
        m_we      = take_ls && ls_we[k];
        m_addr    = take_ls ? ls_addr[k] : if_addr[k];
        m_wdata   = ls_wdata[k];
        m_rd      = smem[k][m_addr[7:0]];
        if (m_we) smem[k][m_addr[7:0]] = m_wdata;
    endtask

    task automatic test_reset();
        logic [5:0] ctl;
        do_reset();
        for (int k = 0; k < NI; k++) begin
            ctl = {if_gnt[k], ls_gnt[k], if_valid[k], ls_valid[k], mem_en[k], mem_we[k]};
            checks++; if (ctl !== 6'b0) begin errors++; $display("FAIL reset_ctl[%0d] got %b want 000000", k, ctl); end
            checks++; if (mem_addr[k] !== 16'h0) begin errors++; $display("FAIL reset_mem_addr[%0d] got %h want 0", k, mem_addr[k]); end
            checks++; if (mem_wdata[k] !== 32'h0) begin errors++; $display("FAIL reset_mem_wdata[%0d] got %h want 0", k, mem_wdata[k]); end
            checks++; if (if_rdata[k] !== 32'h0) begin errors++; $display("FAIL reset_if_rdata[%0d] got %h want 0", k, if_rdata[k]); end
            checks++; if (ls_rdata[k] !== 32'h0) begin errors++; $display("FAIL reset_ls_rdata[%0d] got %h want 0", k, ls_rdata[k]); end
        end
    endtask

    task automatic test_single_fetch();
        do_reset();
        if_req[0] = 1'b1;
        if_addr[0] = 16'h0004;
        tick();
        checks++; if ({if_gnt[0], mem_en[0], mem_we[0], ls_gnt[0]} !== 4'b1100) begin errors++; $display("FAIL fetch_gnt got gnt/en/we/lsgnt %b want 1100", {if_gnt[0], mem_en[0], mem_we[0], ls_gnt[0]}); end
        checks++; if (mem_addr[0] !== 16'h0004) begin errors++; $display("FAIL fetch_addr got %h want 0004", mem_addr[0]); end
        if_req[0] = 1'b0;
        tick();
        checks++; if ({if_gnt[0], mem_en[0], if_valid[0]} !== 3'b000) begin errors++; $display("FAIL fetch_mid got %b want 000", {if_gnt[0], mem_en[0], if_valid[0]}); end
        tick();
        checks++; if ({if_valid[0], ls_valid[0]} !== 2'b10) begin errors++; $display("FAIL fetch_valid got if/ls %b want 10", {if_valid[0], ls_valid[0]}); end
        checks++; if (if_rdata[0] !== 32'h1234ABCD) begin errors++; $display("FAIL fetch_data got %h want 1234abcd", if_rdata[0]); end
        tick();
        checks++; if ({if_valid[0], ls_valid[0]} !== 2'b00) begin errors++; $display("FAIL fetch_valid_pulse got %b want 00", {if_valid[0], ls_valid[0]}); end
        checks++; if (if_rdata[0] !== 32'h1234ABCD) begin errors++; $display("FAIL fetch_data_hold got %h want 1234abcd", if_rdata[0]); end
    endtask

    task automatic test_store_load();
        int we_cnt;
        do_reset();
        we_cnt = 0;
        ls_req[1] = 1'b1;  ls_we[1] = 1'b1;
        ls_addr[1] = 16'h0010;  ls_wdata[1] = 32'hDEADBEEF;
        smem[1][8'h10] = 32'hDEADBEEF;
        for (int i = 1; i <= 5; i++) begin
            tick();
            if (mem_we[1]) we_cnt++;
            if (i == 1) begin
                checks++; if ({ls_gnt[1], mem_en[1], mem_addr[1], mem_wdata[1]} !== {2'b11, 16'h0010, 32'hDEADBEEF}) begin errors++; $display("FAIL store_gnt got gnt %b en %b addr %h wdata %h", ls_gnt[1], mem_en[1], mem_addr[1], mem_wdata[1]); end
                ls_req[1] = 1'b0;  ls_we[1] = 1'b0;
            end
            if (i < 5) begin
                checks++; if (ls_valid[1] !== 1'b0) begin errors++; $display("FAIL store_early_valid at +%0d got 1 want 0", i); end
            end
        end
        checks++; if (ls_valid[1] !== 1'b1) begin errors++; $display("FAIL store_valid got %b want 1", ls_valid[1]); end
        checks++; if (ls_rdata[1] !== 32'h0) begin errors++; $display("FAIL store_rdata_kept got %h want 0", ls_rdata[1]); end
        checks++; if (we_cnt !== 1) begin errors++; $display("FAIL store_we_cycles got %0d want 1", we_cnt); end
        // load raised during DONE, sampled the cycle after (IDLE)
        ls_req[1] = 1'b1;  ls_addr[1] = 16'h0010;
        for (int i = 1; i <= 6; i++) begin
            tick();
            if (i == 2) begin
                checks++; if ({ls_gnt[1], mem_we[1]} !== 2'b10) begin errors++; $display("FAIL load_gnt got gnt/we %b want 10", {ls_gnt[1], mem_we[1]}); end
                ls_req[1] = 1'b0;
            end
            if (i < 6) begin
                checks++; if (ls_valid[1] !== 1'b0) begin errors++; $display("FAIL load_early_valid at +%0d got 1 want 0", i); end
            end
        end
        checks++; if (ls_valid[1] !== 1'b1) begin errors++; $display("FAIL load_valid got %b want 1", ls_valid[1]); end
        checks++; if (ls_rdata[1] !== 32'hDEADBEEF) begin errors++; $display("FAIL load_data got %h want deadbeef", ls_rdata[1]); end
    endtask

    task automatic test_priority();
        int r, n, gc[4];
        bit gl[4];
        do_reset();
        r = cyc;  n = 0;
        if_req[1] = 1'b1;  if_addr[1] = 16'h0020;
        ls_req[1] = 1'b1;  ls_we[1] = 1'b0;  ls_addr[1] = 16'h0030;
        for (int t = 1; t <= 14; t++) begin
            tick();
            checks++; if (if_gnt[1] && ls_gnt[1]) begin errors++; $display("FAIL prio_double_gnt at +%0d got 2 grants want <=1", t); end
            if ((if_gnt[1] || ls_gnt[1]) && n < 4) begin gc[n] = cyc; gl[n] = ls_gnt[1]; n++; end
            if (if_gnt[1]) if_req[1] = 1'b0;
            if (ls_gnt[1]) ls_req[1] = 1'b0;
        end
        checks++; if (n !== 2) begin errors++; $display("FAIL prio_gnt_count got %0d want 2", n); end
        if (n >= 2) begin
            checks++; if ({gl[0], gl[1]} !== 2'b10) begin errors++; $display("FAIL prio_order got ls-flags %b want 10", {gl[0], gl[1]}); end
            checks++; if (gc[0] - r !== 1) begin errors++; $display("FAIL prio_first_gnt got +%0d want +1", gc[0] - r); end
            checks++; if (gc[1] - gc[0] !== 6) begin errors++; $display("FAIL prio_spacing got %0d want 6", gc[1] - gc[0]); end
        end
        checks++; if (if_rdata[1] !== smem[1][8'h20]) begin errors++; $display("FAIL prio_if_data got %h want %h", if_rdata[1], smem[1][8'h20]); end
        checks++; if (ls_rdata[1] !== smem[1][8'h30]) begin errors++; $display("FAIL prio_ls_data got %h want %h", ls_rdata[1], smem[1][8'h30]); end
    endtask

    task automatic test_round_robin();
        int r, n, gc[4];
        bit gl[4];
        bit exp_ls;
        do_reset();
        r = cyc;  n = 0;
        if_req[0] = 1'b1;  if_addr[0] = 16'h0008;
        ls_req[0] = 1'b1;  ls_we[0] = 1'b0;  ls_addr[0] = 16'h000C;
        for (int t = 1; t <= 20; t++) begin
            tick();
            if ((if_gnt[0] || ls_gnt[0]) && n < 4) begin gc[n] = cyc; gl[n] = ls_gnt[0]; n++; end
        end
        clear_inputs();
        checks++; if (n !== 4) begin errors++; $display("FAIL rr_gnt_count got %0d want 4", n); end
        for (int i = 0; i < n; i++) begin
`ifdef ARB_RR_EN
            exp_ls = (i % 2) == 0;
`else
            exp_ls = 1'b1;
`endif
            checks++; if (gl[i] !== exp_ls) begin errors++; $display("FAIL rr_order[%0d] got ls=%b want ls=%b", i, gl[i], exp_ls); end
            checks++; if (gc[i] - r !== 1 + 4 * i) begin errors++; $display("FAIL rr_gnt_cycle[%0d] got +%0d want +%0d", i, gc[i] - r, 1 + 4 * i); end
        end
    endtask

    task automatic test_reset_mid_access();
        bit got;
        do_reset();
        for (int j = 0; j < 2; j++) begin
            if (j == 0) begin ls_req[1] = 1'b1; ls_we[1] = 1'b0; ls_addr[1] = 16'h0044; end
            else begin if_req[1] = 1'b1; if_addr[1] = 16'h0048; end
            got = 1'b0;
            for (int t = 0; t < 20 && !got; t++) begin
                tick();
                if (if_gnt[1]) if_req[1] = 1'b0;
                if (ls_gnt[1]) ls_req[1] = 1'b0;
                if (if_valid[1] || ls_valid[1]) got = 1'b1;
            end
            checks++; if (!got) begin errors++; $display("FAIL rstmid_prelim%0d timeout got no valid want valid", j); end
            tick();
        end
        checks++; if (ls_rdata[1] !== smem[1][8'h44]) begin errors++; $display("FAIL rstmid_prelim_ls got %h want %h", ls_rdata[1], smem[1][8'h44]); end
        if_req[1] = 1'b1;  if_addr[1] = 16'h0050;
        tick();
        tick();
        rst = 1'b1;
        tick();
        checks++; if ({if_gnt[1], mem_en[1], if_valid[1], ls_valid[1]} !== 4'b0) begin errors++; $display("FAIL rstmid_idle got gnt/en/ifv/lsv %b want 0000", {if_gnt[1], mem_en[1], if_valid[1], ls_valid[1]}); end
        checks++; if (if_rdata[1] !== 32'h0) begin errors++; $display("FAIL rstmid_if_rdata got %h want 0", if_rdata[1]); end
        checks++; if (ls_rdata[1] !== 32'h0) begin errors++; $display("FAIL rstmid_ls_rdata got %h want 0", ls_rdata[1]); end
        rst = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            tick();
            if (i == 1) begin
                checks++; if ({if_gnt[1], mem_addr[1]} !== {1'b1, 16'h0050}) begin errors++; $display("FAIL rstmid_regrant got gnt %b addr %h want 1 0050", if_gnt[1], mem_addr[1]); end
                if_req[1] = 1'b0;
            end
            if (i < 5) begin
                checks++; if (if_valid[1] !== 1'b0) begin errors++; $display("FAIL rstmid_stray_valid at +%0d got 1 want 0", i); end
            end
        end
        checks++; if ({if_valid[1], if_rdata[1]} !== {1'b1, smem[1][8'h50]}) begin errors++; $display("FAIL rstmid_fetch got valid %b data %h want 1 %h", if_valid[1], if_rdata[1], smem[1][8'h50]); end
    endtask

    task automatic test_lat15();
        int r, en_cnt, v_cnt, v_cyc, g_cyc;
        do_reset();
        r = cyc;  en_cnt = 0;  v_cnt = 0;  v_cyc = -1;  g_cyc = -1;
        ls_req[2] = 1'b1;  ls_we[2] = 1'b0;  ls_addr[2] = 16'h0077;
        for (int t = 1; t <= 22; t++) begin
            tick();
            if (mem_en[2]) en_cnt++;
            if (ls_gnt[2]) begin g_cyc = cyc; ls_req[2] = 1'b0; end
            if (ls_valid[2]) begin v_cnt++; v_cyc = cyc; end
        end
        checks++; if (g_cyc - r !== 1) begin errors++; $display("FAIL lat15_gnt got +%0d want +1", g_cyc - r); end
        checks++; if (v_cyc - r !== 17) begin errors++; $display("FAIL lat15_valid got +%0d want +17", v_cyc - r); end
        checks++; if (v_cnt !== 1) begin errors++; $display("FAIL lat15_valid_count got %0d want 1", v_cnt); end
        checks++; if (en_cnt !== 1) begin errors++; $display("FAIL lat15_en_count got %0d want 1", en_cnt); end
        checks++; if (ls_rdata[2] !== smem[2][8'h77]) begin errors++; $display("FAIL lat15_data got %h want %h", ls_rdata[2], smem[2][8'h77]); end
    endtask

    task automatic test_random(input int k);
        logic [5:0] got, want;
        do_reset();
        for (int t = 0; t < 300; t++) begin
            model_expect(k);
            got  = {if_gnt[k], ls_gnt[k], if_valid[k], ls_valid[k], mem_en[k], mem_we[k]};
            want = {e_if_gnt, e_ls_gnt, e_if_valid, e_ls_valid, e_mem_en, e_mem_we};
            checks++; if (got !== want) begin errors++; $display("FAIL rand%0d_ctrl cyc %0d got %b want %b", k, t, got, want); end
            if (e_busy) begin
                checks++; if (mem_addr[k] !== m_addr) begin errors++; $display("FAIL rand%0d_addr cyc %0d got %h want %h", k, t, mem_addr[k], m_addr); end
            end
            if (e_mem_we) begin
                checks++; if (mem_wdata[k] !== m_wdata) begin errors++; $display("FAIL rand%0d_wdata cyc %0d got %h want %h", k, t, mem_wdata[k], m_wdata); end
            end
            checks++; if (if_rdata[k] !== e_if_rdata) begin errors++; $display("FAIL rand%0d_if_rdata cyc %0d got %h want %h", k, t, if_rdata[k], e_if_rdata); end
            checks++; if (ls_rdata[k] !== e_ls_rdata) begin errors++; $display("FAIL rand%0d_ls_rdata cyc %0d got %h want %h", k, t, ls_rdata[k], e_ls_rdata); end
            if (e_if_gnt) if_req[k] = 1'b0;
            if (e_ls_gnt) ls_req[k] = 1'b0;
            if (!if_req[k] && $urandom_range(0, 2) == 0) begin
                if_req[k] = 1'b1;
                if_addr[k] = 16'($urandom);
            end
            if (!ls_req[k] && $urandom_range(0, 2) == 0) begin
                ls_req[k] = 1'b1;
                ls_we[k] = 1'($urandom);
                ls_addr[k] = 16'($urandom);
                ls_wdata[k] = $urandom;
            end
            model_sample(k);
            tick();
        end
        clear_inputs();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired got no finish want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        clear_inputs();
        for (int k = 0; k < NI; k++)
            for (int a = 0; a < 256; a++) smem[k][a] = init_word(8'(a));
        model_reset();
        test_reset();
        test_single_fetch();
        test_store_load();
        test_priority();
        test_round_robin();
        test_reset_mid_access();
        test_lat15();
        for (int k = 0; k < NI; k++) test_random(k);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arb.md
# mem_arb

Single-port memory arbiter for the SISC processor. It shares one unified instruction/data memory between the instruction-fetch path (PC → IR) and the load/store path driven by the control unit. It serializes accesses with a small FSM, latches the winning request, and returns read data with a one-cycle valid pulse to the requester that owns the access.

## Interface

Parameters:
- AW, default 16: address width; matches the PC width.
- DW, default 32: data width; matches the instruction and register width.
- MEM_LAT, default 1, legal range 1..15: memory read latency in cycles, measured from the cycle mem_en is high to the cycle mem_rdata is valid.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- if_req  in  1  fetch request; requester holds it high until if_gnt.
- if_addr  in  AW  fetch address; sampled on the grant edge.
- if_gnt  out  1  one-cycle pulse; fetch request accepted.
- if_valid  out  1  one-cycle pulse; if_rdata updated.
- if_rdata  out  DW  fetched word; held until the next fetch completes.
- ls_req  in  1  load/store request; requester holds it high until ls_gnt.
- ls_we  in  1  1 = store, 0 = load; sampled on the grant edge.
- ls_addr  in  AW  load/store address; sampled on the grant edge.
- ls_wdata  in  DW  store data; sampled on the grant edge.
- ls_gnt  out  1  one-cycle pulse; load/store request accepted.
- ls_valid  out  1  one-cycle pulse; access complete (loads and stores).
- ls_rdata  out  DW  loaded word; held until the next load completes.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_rdata  in  DW  memory read data; valid MEM_LAT cycles after mem_en.

## Operation

- FSM states:
  - IDLE: no access in flight.
  - BUSY: access in flight; 4-bit counter cnt runs 0..MEM_LAT.
  - DONE: one cycle; owner's valid pulse is high.
- Transitions:
  - IDLE → BUSY on an edge where if_req or ls_req is high. Winner is chosen by the priority rule. Owner, address, we and wdata are latched; cnt ← 0.
  - BUSY: cnt increments each edge.
  - BUSY → DONE on the edge where cnt == MEM_LAT. For a load or fetch, mem_rdata is captured into the owner's rdata register on that edge.
  - DONE → IDLE unconditionally.
- Outputs:
  - gnt for the owner is high in the first BUSY cycle only (cnt == 0).
  - mem_en is high only when cnt == 0. mem_we = latched we & (cnt == 0).
  - mem_addr and mem_wdata hold the latched values for the whole BUSY phase.
  - Fetches always have mem_we = 0.
- Priority (default fixed): when both requests are sampled high in IDLE, ls wins and if_req stays pending.
- Stores: ls_valid pulses in DONE exactly as for loads; ls_rdata is not modified.
- Requests arriving during BUSY or DONE are ignored until IDLE samples them. Requesters must keep req high.
- Throughput: one access per MEM_LAT + 3 cycles.

## Timing

- Request sampled at the end of cycle R:
  - gnt and mem_en high in cycle R+1.
  - mem_rdata valid in R+1+MEM_LAT and captured at the end of that cycle.
  - valid high in R+2+MEM_LAT.
  - IDLE in R+3+MEM_LAT; the earliest next grant is cycle R+4+MEM_LAT.
- For MEM_LAT = 1: gnt in R+1, valid in R+3.
- Reset values: state IDLE, cnt 0, all gnt/valid/mem_* outputs 0, if_rdata and ls_rdata 0, round-robin pointer = "if last granted".
- Reset asserted mid-access aborts the access: IDLE on the next edge, no valid pulse, rdata cleared to 0.
- Reset and req high on the same edge: reset wins; the request is re-sampled after reset deasserts.
- MEM_LAT outside 1..15 is illegal; elaboration must fail with $error.

## Configuration

- ARB_RR_EN defined: round-robin arbitration.
  - A 1-bit pointer records the last granted port.
  - On a simultaneous request, the port not last granted wins.
  - A single request always wins regardless of the pointer.
  - The pointer updates on every grant.
  - Since the reset pointer is "if last", ls wins the first tie.
- ARB_RR_EN undefined: fixed priority, ls over if. No pointer flop exists. Back-to-back ls requests may starve fetch.

## Test plan

- Single fetch, MEM_LAT=1, memory word at address 16'h0004 = 32'h1234ABCD; pulse if_req, if_addr=16'h0004 → if_gnt and mem_en in R+1 with mem_addr=16'h0004, mem_we=0; if_valid in R+3 with if_rdata=32'h1234ABCD; ls_valid stays 0.
- Store then load, MEM_LAT=3: store ls_addr=16'h0010, ls_wdata=32'hDEADBEEF, then load the same address → mem_we high for exactly one cycle; store ls_valid at R+5 with ls_rdata unchanged; the load returns 32'hDEADBEEF with ls_valid six cycles after its sample edge.
- Simultaneous if_req and ls_req held high for two accesses, fixed priority → ls granted first, fetch granted second; exactly one gnt pulse per access; no grant within MEM_LAT+3 cycles of the previous one.
- With ARB_RR_EN, both requests held continuously for four accesses → grant order ls, if, ls, if.
- Reset asserted during BUSY (cnt=1, MEM_LAT=3) → next cycle IDLE; no valid pulse; if_rdata and ls_rdata = 0; a fresh fetch after reset completes normally.
- MEM_LAT=15, single load → valid exactly 17 cycles after the request sample edge; mem_en high for exactly one cycle.
